// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the decode/execute boundary and the
// multi-cycle MUL/DIV/MOD sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_mul;
  logic             is_div;
  logic             is_mod;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, is_mul, is_div, is_mod, op_a, op_b, flush,
    input  stall, busy, done, result, div_by_zero
  );

  modport slave (
    input  start, is_mul, is_div, is_mod, op_a, op_b, flush,
    output stall, busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle execute controller: iterative shift-add multiply and restoring
// signed divide/modulo, holding the pipeline until a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_accum;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_opnd;
  logic             r_negQuo;
  logic             r_negRem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_divByZero;

  logic             w_valid;
  logic             w_accept;
  op_t              w_reqOp;
  logic             w_reqDivZero;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_dbzResult;
  logic [WIDTH:0]   w_divShifted;
  logic [WIDTH:0]   w_divDiff;
  logic [WIDTH-1:0] w_accumNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_opndNext;
  logic [WIDTH-1:0] w_final;

  // Request decode with mul > div > mod priority.
  always_comb begin
    w_valid      = (r_state == S_IDLE) & bus.start & (bus.is_mul | bus.is_div | bus.is_mod);
    w_accept     = w_valid & ~bus.flush;
    w_reqOp      = bus.is_mul ? OP_MUL : (bus.is_div ? OP_DIV : OP_MOD);
    w_reqDivZero = (w_reqOp != OP_MUL) & (bus.op_b == '0);
    w_absA       = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    w_absB       = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    w_dbzResult  = (w_reqOp == OP_DIV) ? '1 : bus.op_a;
  end

  // One iteration: r_accum is the product or partial remainder, r_shift holds
  // the multiplier bits (consumed LSB first) or the dividend/quotient bits
  // (MSB first), r_opnd is the shifting multiplicand or the divisor magnitude.
  always_comb begin
    w_divShifted = {r_accum, r_shift[WIDTH-1]};
    w_divDiff    = w_divShifted - {1'b0, r_opnd};
    if (r_op == OP_MUL) begin
      w_accumNext = r_accum + (r_shift[0] ? r_opnd : '0);
      w_shiftNext = r_shift >> 1;
      w_opndNext  = r_opnd << 1;
    end else begin
      w_accumNext = w_divDiff[WIDTH] ? w_divShifted[WIDTH-1:0] : w_divDiff[WIDTH-1:0];
      w_shiftNext = {r_shift[WIDTH-2:0], ~w_divDiff[WIDTH]};
      w_opndNext  = r_opnd;
    end
    case (r_op)
      OP_DIV:  w_final = r_negQuo ? -w_shiftNext : w_shiftNext;
      OP_MOD:  w_final = r_negRem ? -w_accumNext : w_accumNext;
      default: w_final = w_accumNext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_count     <= '0;
      r_accum     <= '0;
      r_shift     <= '0;
      r_opnd      <= '0;
      r_negQuo    <= 1'b0;
      r_negRem    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_divByZero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= w_reqOp;
            r_count  <= CNT_W'(WIDTH);
            r_negQuo <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            r_negRem <= bus.op_a[WIDTH-1];
            if (w_reqOp == OP_MUL) begin
              r_accum <= '0;
              r_shift <= bus.op_b;
              r_opnd  <= bus.op_a;
            end else begin
              r_accum <= '0;
              r_shift <= w_absA;
              r_opnd  <= w_absB;
            end
            if (w_reqDivZero) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_result    <= w_dbzResult;
              r_divByZero <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_accum <= w_accumNext;
            r_shift <= w_shiftNext;
            r_opnd  <= w_opndNext;
            r_count <= r_count - 1'b1;
            if (r_count == CNT_W'(1)) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_result    <= w_final;
              r_divByZero <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the request cycle itself already holds decode.
  assign bus.stall       = ~rst & (w_valid | (r_state == S_BUSY));
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_divByZero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain
// integer-arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  logic [WIDTH-1:0] lastResult;
  logic             lastDbz;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour from the arithmetic definition of MUL/DIV/MOD.
  task automatic refModel(input logic m, input logic d, input logic md,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dbz,
                          output int lat, output logic ok);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ok  = m | d | md;
    dbz = 1'b0;
    lat = WIDTH + 1;
    res = 32'h0;
    if (m) begin
      p   = sa * sb;
      res = p[31:0];
    end else if (d || md) begin
      if (b == 32'h0) begin
        dbz = 1'b1;
        lat = 1;
        res = d ? 32'hFFFF_FFFF : a;
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        res = d ? q[31:0] : r[31:0];
      end
    end
  endtask

  task automatic idleInputs();
    bus.start  = 1'b0;
    bus.is_mul = 1'b0;
    bus.is_div = 1'b0;
    bus.is_mod = 1'b0;
    bus.flush  = 1'b0;
  endtask

  // Issues one request and follows it cycle by cycle until it completes.
  task automatic applyStimulus(input logic m, input logic d, input logic md,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    logic        expDbz;
    int          lat;
    logic        ok;
    refModel(m, d, md, a, b, expRes, expDbz, lat, ok);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_mul = m;
    bus.is_div = d;
    bus.is_mod = md;
    bus.op_a   = a;
    bus.op_b   = b;
    #1 checkOutput("stallAtStart", 32'(bus.stall), 32'(ok));
    @(posedge clk);
    #1;
    idleInputs();
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    if (!ok) begin
      @(negedge clk);
      checkOutput("noFlagBusy", 32'(bus.busy), 32'h0);
      checkOutput("noFlagDone", 32'(bus.done), 32'h0);
      checkOutput("noFlagStall", 32'(bus.stall), 32'h0);
      checkOutput("noFlagResultHeld", bus.result, lastResult);
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      checkOutput("busy", 32'(bus.busy), 32'(c < lat));
      checkOutput("done", 32'(bus.done), 32'(c == lat));
      checkOutput("stall", 32'(bus.stall), 32'(c < lat));
    end
    checkOutput("result", bus.result, expRes);
    checkOutput("divByZero", 32'(bus.div_by_zero), 32'(expDbz));
    lastResult = expRes;
    lastDbz    = expDbz;
    @(negedge clk);
    checkOutput("donePulseEnds", 32'(bus.done), 32'h0);
    checkOutput("resultHeld", bus.result, lastResult);
  endtask

  task automatic flushTest();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_mul = 1'b1;
    bus.op_a   = 32'd12345;
    bus.op_b   = 32'd678;
    @(posedge clk);
    #1 idleInputs();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checkOutput("flushBusyBefore", 32'(bus.busy), 32'h1);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flushBusyAfter", 32'(bus.busy), 32'h0);
    checkOutput("flushStallAfter", 32'(bus.stall), 32'h0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checkOutput("flushNoDone", 32'(bus.done), 32'h0);
    end
    checkOutput("flushResultHeld", bus.result, lastResult);
    checkOutput("flushDbzHeld", 32'(bus.div_by_zero), 32'(lastDbz));
  endtask

  task automatic flushWithStartTest();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = 1'b1;
    bus.op_a   = 32'd50;
    bus.op_b   = 32'd0;
    bus.flush  = 1'b1;
    @(posedge clk);
    #1 idleInputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("flushStartBusy", 32'(bus.busy), 32'h0);
      checkOutput("flushStartDone", 32'(bus.done), 32'h0);
    end
    checkOutput("flushStartDbz", 32'(bus.div_by_zero), 32'(lastDbz));
  endtask

  task automatic resetTest();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = 1'b1;
    bus.op_a   = 32'hFFFF_FC18;
    bus.op_b   = 32'd7;
    @(posedge clk);
    #1 idleInputs();
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("rstStallLow", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", 32'(bus.busy), 32'h0);
    checkOutput("rstDone", 32'(bus.done), 32'h0);
    checkOutput("rstStall", 32'(bus.stall), 32'h0);
    checkOutput("rstResult", bus.result, 32'h0);
    checkOutput("rstDbz", 32'(bus.div_by_zero), 32'h0);
    lastResult = 32'h0;
    lastDbz    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checkOutput("rstNoDone", 32'(bus.done), 32'h0);
    end
  endtask

  // Operands biased towards small magnitudes, zero divisors and INT_MIN / -1.
  function automatic logic [31:0] pickOperand(input logic allowZero);
    int sel;
    sel = int'($urandom_range(0, 7));
    if (allowZero && sel == 0) return 32'h0;
    if (sel == 1) return 32'hFFFF_FFFF;
    if (sel == 2) return 32'h8000_0000;
    if (sel <= 4) return 32'($signed($urandom_range(0, 2000)) - 1000);
    return $urandom;
  endfunction

  initial begin
    logic m, d, md;
    nChecks    = 0;
    nFails     = 0;
    lastResult = 32'h0;
    lastDbz    = 1'b0;
    rst        = 1'b1;
    idleInputs();
    bus.op_a   = 32'h0;
    bus.op_b   = 32'h0;
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.is_mul = 1'b1;
    #1 checkOutput("stallDuringReset", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      idleInputs();
    end
    @(negedge clk);
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    checkOutput("resetDone", 32'(bus.done), 32'h0);
    checkOutput("resetResult", bus.result, 32'h0);
    checkOutput("resetDbz", 32'(bus.div_by_zero), 32'h0);

    $display("[TB] directed operations");
    applyStimulus(1, 0, 0, 32'd7, 32'hFFFF_FFFD);
    applyStimulus(0, 1, 0, 32'hFFFF_FFEF, 32'd5);
    applyStimulus(0, 0, 1, 32'hFFFF_FFEF, 32'd5);
    applyStimulus(0, 1, 0, 32'd100, 32'd0);
    applyStimulus(0, 0, 1, 32'd100, 32'd0);
    applyStimulus(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    flushTest();
    applyStimulus(1, 0, 0, 32'd6, 32'd6);
    applyStimulus(1, 1, 0, 32'd9, 32'd2);
    applyStimulus(0, 1, 1, 32'd9, 32'd2);
    applyStimulus(0, 0, 0, 32'd9, 32'd2);
    flushWithStartTest();
    applyStimulus(1, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    resetTest();

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      m  = 1'($urandom_range(0, 3) == 0);
      d  = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      applyStimulus(m, d, md, pickOperand(1'b0), pickOperand(1'b1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
